uart_transceiver_param: RTL and testbench
=========================================

// Module: uart_transceiver_param
// PURPOSE
// Full-duplex UART transceiver with independent TX and RX engines sharing one clock.
// Generalises the fixed one-bit-per-clock, 8-bit UART_2 link: data width, parity, stop bits and bit period are parameters.
// Adds a TX valid/ready handshake and an RX receiver with mid-bit sampling, false-start rejection and error flags.
// Instantiated once per link end in the transmitter/receiver test system; TX_SERIAL of one instance drives RX_SERIAL of the other.
// PARAMETERS
// DATA_BITS     8   payload bits per frame, legal 5..9, sent LSB first
// PARITY_EN     1   1 = parity bit follows the data, 0 = no parity bit
// PARITY_ODD    0   0 = even parity (data+parity ones count even), 1 = odd parity
// STOP_BITS     1   stop bits per frame, legal 1 or 2
// CLKS_PER_BIT  16  clocks per serial bit, legal >= 4
// PORTS
// UART_CLK       in   1          single clock, all logic on the rising edge
// UART_RST_N     in   1          asynchronous reset, active-low
// TX_DATA        in   DATA_BITS  word to send, captured on handshake
// TX_VALID       in   1          TX request
// TX_READY       out  1          TX engine idle; handshake = TX_VALID & TX_READY at a rising edge
// TX_SERIAL      out  1          serial line out, idles high
// RX_SERIAL      in   1          serial line in, asynchronous to UART_CLK
// RX_DATA        out  DATA_BITS  last received word
// RX_VALID       out  1          one-cycle pulse, new RX_DATA and error flags valid
// RX_PARITY_ERR  out  1          parity mismatch on the last frame (0 when PARITY_EN=0)
// RX_FRAME_ERR   out  1          a stop bit sampled low on the last frame
// BEHAVIOUR
// - Reset (async, immediate): TX_SERIAL=1, TX_READY=1, RX_DATA=0, RX_VALID=0, both error flags 0, both FSMs IDLE, counters 0, RX synchroniser flops=1.
// - TX FSM IDLE->START->DATA->PARITY (skipped if PARITY_EN=0)->STOP->IDLE. TX_READY=1 only in IDLE.
// - TX handshake captures TX_DATA into a shadow register. The next cycle TX_READY=0 and TX_SERIAL=0 (start bit).
// - TX: each bit lasts exactly CLKS_PER_BIT cycles. Data goes out LSB first from the shadow register; changes on TX_DATA mid-frame are ignored.
// - TX parity = ^data (even) or ~^data (odd). STOP drives 1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE for at least 1 cycle with the line high.
// - TX back-to-back: with TX_VALID held high, handshakes occur every 1+(1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
// - RX input: 2-flop synchroniser on RX_SERIAL. All RX decisions use the synchronised value rx_s.
// - RX FSM IDLE->START->DATA->PARITY (skipped if PARITY_EN=0)->STOP->IDLE, plus WAIT_HIGH.
// - RX start: in IDLE, rx_s=0 enters START with the baud counter cleared. At count CLKS_PER_BIT/2-1 (integer division), rx_s is sampled.
// - RX false start: if that sample is 1, return to IDLE with no output change (glitch rejection).
// - RX sampling: each later bit is sampled CLKS_PER_BIT cycles after the previous sample (mid-bit). Data shifts in LSB first.
// - RX parity: the received parity is compared to the parity computed over the data. RX_PARITY_ERR is 1 on mismatch.
// - RX stop: every stop bit is sampled. Any stop sample of 0 sets RX_FRAME_ERR.
// - RX completion: the cycle after the last stop sample, RX_DATA, RX_PARITY_ERR and RX_FRAME_ERR update and RX_VALID=1 for one cycle. Data is delivered even when an error flag is set.
// - RX flags hold their value until the next RX_VALID.
// - RX after a good stop: FSM returns to IDLE, so a start bit that begins immediately is detected.
// - RX after a framing error: FSM enters WAIT_HIGH and goes to IDLE only after rx_s=1, so a break is not decoded as frames.
// - TX and RX are fully independent. Simultaneous TX handshake and RX completion in the same cycle are both honoured.
// - Counter widths: baud counter $clog2(CLKS_PER_BIT), bit counter $clog2(DATA_BITS+1). Counters wrap only by explicit clear, never by overflow.
// - Reset asserted mid-frame aborts both frames. The line returns high at once and no RX_VALID is produced for the partial frame.
// TESTING
// T1 defaults, TX_DATA=0xA5 handshake: TX_SERIAL = 0,1,0,1,0,0,1,0,1,0(par),1, 16 cycles each. TX_READY low for 176 cycles.
// T2 loopback TX_SERIAL->RX_SERIAL, 0xA5 then 0x3C: two RX_VALID pulses, RX_DATA=0xA5 then 0x3C, both error flags 0 throughout.
// T3 TX_VALID held with 0x00 then 0xFF: handshakes exactly 177 cycles apart, line high for 1 cycle between frames.
// T4 RX frame 0x01 with parity bit 0 (even needs 1): RX_DATA=0x01, RX_VALID pulse, RX_PARITY_ERR=1. A 4-cycle low glitch on RX_SERIAL gives no RX_VALID.
// T5 RX frame 0x55 with stop bit 0, line held low 300 cycles: RX_FRAME_ERR=1, one RX_VALID only. The next good frame decodes after the line returns high.
// T6 DATA_BITS=7, PARITY_EN=0, STOP_BITS=2, CLKS_PER_BIT=4, 0x55 in loopback: 40-cycle frame, RX_DATA=0x55. Reset mid-frame gives TX_SERIAL=1 and no RX_VALID.

Source files
------------

// File: rtl/uart_transceiver_param.sv
// uart_transceiver_param
// Full-duplex UART with independent TX and RX engines on one clock.
// Frame: start(0), DATA_BITS LSB first, optional parity, STOP_BITS stop(1).
// Each bit lasts CLKS_PER_BIT clocks. RX samples mid-bit from a 2-flop
// synchronised copy of the line, rejects short start glitches and reports
// parity / framing errors alongside the data.
//
// Ports
//   UART_CLK, UART_RST_N           clock, async active-low reset
//   TX_DATA, TX_VALID, TX_READY    TX word and valid/ready handshake
//   TX_SERIAL                      serial line out (idles high)
//   RX_SERIAL                      serial line in (asynchronous)
//   RX_DATA, RX_VALID              last received word, one-cycle valid pulse
//   RX_PARITY_ERR, RX_FRAME_ERR    error flags of the last frame
//
// TX states
//   state       | meaning
//   TXS_IDLE    | line high, ready for a handshake
//   TXS_START   | driving the start bit
//   TXS_DATA    | shifting payload out LSB first
//   TXS_PARITY  | driving the parity bit
//   TXS_STOP    | driving STOP_BITS stop bits
//
// RX states
//   state         | meaning
//   RXS_IDLE      | waiting for the line to go low
//   RXS_START     | half-bit wait, then confirm the start bit
//   RXS_DATA      | sampling payload bits
//   RXS_PARITY    | sampling the parity bit
//   RXS_STOP      | sampling stop bits, delivering the word
//   RXS_WAIT_HIGH | after a framing error, wait for the line to return high

module uart_transceiver_param #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 UART_CLK,
  input  logic                 UART_RST_N,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_VALID,
  output logic                 TX_READY,
  output logic                 TX_SERIAL,
  input  logic                 RX_SERIAL,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  output logic                 RX_PARITY_ERR,
  output logic                 RX_FRAME_ERR
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              HAS_PAR   = (PARITY_EN != 0);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {
    TXS_IDLE, TXS_START, TXS_DATA, TXS_PARITY, TXS_STOP
  } tx_state_t;

  tx_state_t              tx_state_q, tx_state_d;
  logic [BAUD_W-1:0]      tx_baud_q, tx_baud_d;
  logic [BIT_W-1:0]       tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_par_q, tx_par_d;
  logic                   tx_baud_end;
  logic                   tx_ready;
  logic                   tx_line;

  assign tx_baud_end = (tx_baud_q == BAUD_LAST);

  always_ff @(posedge UART_CLK or negedge UART_RST_N) begin
    if (!UART_RST_N) begin
      tx_state_q <= TXS_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    case (tx_state_q)
      TXS_IDLE: begin
        if (TX_VALID) begin
          // Parity is fixed at capture so later TX_DATA changes cannot leak in.
          tx_shift_d = TX_DATA;
          tx_par_d   = (^TX_DATA) ^ PAR_ODD;
          tx_baud_d  = '0;
          tx_state_d = TXS_START;
        end
      end
      TXS_START: begin
        if (tx_baud_end) begin
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = TXS_DATA;
        end else begin
          tx_baud_d = tx_baud_q + BAUD_W'(1);
        end
      end
      TXS_DATA: begin
        if (tx_baud_end) begin
          tx_baud_d  = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == DATA_LAST) begin
            tx_bit_d   = '0;
            tx_state_d = HAS_PAR ? TXS_PARITY : TXS_STOP;
          end else begin
            tx_bit_d = tx_bit_q + BIT_W'(1);
          end
        end else begin
          tx_baud_d = tx_baud_q + BAUD_W'(1);
        end
      end
      TXS_PARITY: begin
        if (tx_baud_end) begin
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = TXS_STOP;
        end else begin
          tx_baud_d = tx_baud_q + BAUD_W'(1);
        end
      end
      TXS_STOP: begin
        if (tx_baud_end) begin
          tx_baud_d = '0;
          if (tx_bit_q == STOP_LAST) begin
            tx_bit_d   = '0;
            tx_state_d = TXS_IDLE;
          end else begin
            tx_bit_d = tx_bit_q + BIT_W'(1);
          end
        end else begin
          tx_baud_d = tx_baud_q + BAUD_W'(1);
        end
      end
      default: tx_state_d = TXS_IDLE;
    endcase
  end

  always_comb begin
    tx_ready = 1'b0;
    tx_line  = 1'b1;
    case (tx_state_q)
      TXS_IDLE:   tx_ready = 1'b1;
      TXS_START:  tx_line  = 1'b0;
      TXS_DATA:   tx_line  = tx_shift_q[0];
      TXS_PARITY: tx_line  = tx_par_q;
      default:    tx_line  = 1'b1;
    endcase
  end

  assign TX_READY  = tx_ready;
  assign TX_SERIAL = tx_line;

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {
    RXS_IDLE, RXS_START, RXS_DATA, RXS_PARITY, RXS_STOP, RXS_WAIT_HIGH
  } rx_state_t;

  rx_state_t              rx_state_q, rx_state_d;
  logic                   rx_meta_q, rx_s_q;
  logic [BAUD_W-1:0]      rx_baud_q, rx_baud_d;
  logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_perr_acc_q, rx_perr_acc_d;
  logic                   rx_ferr_acc_q, rx_ferr_acc_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_perr_q, rx_perr_d;
  logic                   rx_ferr_q, rx_ferr_d;
  logic                   rx_sample;
  logic                   rx_frame_bad;

  always_ff @(posedge UART_CLK or negedge UART_RST_N) begin
    if (!UART_RST_N) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_state_q    <= RXS_IDLE;
      rx_baud_q     <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_perr_acc_q <= 1'b0;
      rx_ferr_acc_q <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_ferr_q     <= 1'b0;
    end else begin
      rx_meta_q     <= RX_SERIAL;
      rx_s_q        <= rx_meta_q;
      rx_state_q    <= rx_state_d;
      rx_baud_q     <= rx_baud_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_perr_acc_q <= rx_perr_acc_d;
      rx_ferr_acc_q <= rx_ferr_acc_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_perr_q     <= rx_perr_d;
      rx_ferr_q     <= rx_ferr_d;
    end
  end

  // Sample strobe: half a bit into the start bit, then one full bit apart.
  always_comb begin
    rx_sample = 1'b0;
    case (rx_state_q)
      RXS_START:                    rx_sample = (rx_baud_q == BAUD_HALF);
      RXS_DATA, RXS_PARITY, RXS_STOP: rx_sample = (rx_baud_q == BAUD_LAST);
      default:                      rx_sample = 1'b0;
    endcase
  end

  assign rx_frame_bad = rx_ferr_acc_q | ~rx_s_q;

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_baud_d     = rx_baud_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_perr_acc_d = rx_perr_acc_q;
    rx_ferr_acc_d = rx_ferr_acc_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    rx_perr_d     = rx_perr_q;
    rx_ferr_d     = rx_ferr_q;
    if (rx_state_q != RXS_IDLE && rx_state_q != RXS_WAIT_HIGH) begin
      rx_baud_d = rx_sample ? '0 : rx_baud_q + BAUD_W'(1);
    end
    case (rx_state_q)
      RXS_IDLE: begin
        if (!rx_s_q) begin
          rx_baud_d     = '0;
          rx_perr_acc_d = 1'b0;
          rx_ferr_acc_d = 1'b0;
          rx_state_d    = RXS_START;
        end
      end
      RXS_START: begin
        if (rx_sample) begin
          rx_bit_d   = '0;
          // Line already high again: treat as a glitch, no output change.
          rx_state_d = rx_s_q ? RXS_IDLE : RXS_DATA;
        end
      end
      RXS_DATA: begin
        if (rx_sample) begin
          rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_LAST) begin
            rx_bit_d   = '0;
            rx_state_d = HAS_PAR ? RXS_PARITY : RXS_STOP;
          end else begin
            rx_bit_d = rx_bit_q + BIT_W'(1);
          end
        end
      end
      RXS_PARITY: begin
        if (rx_sample) begin
          rx_perr_acc_d = rx_s_q ^ (^rx_shift_q) ^ PAR_ODD;
          rx_bit_d      = '0;
          rx_state_d    = RXS_STOP;
        end
      end
      RXS_STOP: begin
        if (rx_sample) begin
          rx_ferr_acc_d = rx_frame_bad;
          if (rx_bit_q == STOP_LAST) begin
            rx_bit_d   = '0;
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            rx_perr_d  = HAS_PAR & rx_perr_acc_q;
            rx_ferr_d  = rx_frame_bad;
            // A low stop may be a break; do not re-arm until the line is high.
            rx_state_d = rx_frame_bad ? RXS_WAIT_HIGH : RXS_IDLE;
          end else begin
            rx_bit_d = rx_bit_q + BIT_W'(1);
          end
        end
      end
      RXS_WAIT_HIGH: begin
        if (rx_s_q) rx_state_d = RXS_IDLE;
      end
      default: rx_state_d = RXS_IDLE;
    endcase
  end

  assign RX_DATA       = rx_data_q;
  assign RX_VALID      = rx_valid_q;
  assign RX_PARITY_ERR = rx_perr_q;
  assign RX_FRAME_ERR  = rx_ferr_q;

endmodule

// File: tb/tb_uart_transceiver_param.sv
`timescale 1ns/1ps
module tb_uart_transceiver_param;

  localparam int CPB    = 16;
  localparam int DB     = 8;
  localparam int FRAME  = (1 + DB + 1 + 1) * CPB;
  localparam int CPB6   = 4;
  localparam int DB6    = 7;
  localparam int FRAME6 = (1 + DB6 + 0 + 2) * CPB6;
  // 2 sync flops + 1 idle-detect cycle + half bit + remaining bits
  localparam int RX_LAT = 3 + CPB / 2 + (DB + 1 + 1) * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_serial;
  logic       rx_drive, loop_en, rx_line;
  logic [7:0] rx_data;
  logic       rx_valid, rx_perr, rx_ferr;
  logic [6:0] tx6_data;
  logic       tx6_valid, tx6_ready, tx6_serial;
  logic [6:0] rx6_data;
  logic       rx6_valid, rx6_perr, rx6_ferr;

  assign rx_line = loop_en ? tx_serial : rx_drive;

  uart_transceiver_param dut (
    .UART_CLK(clk), .UART_RST_N(rst_n),
    .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready), .TX_SERIAL(tx_serial),
    .RX_SERIAL(rx_line), .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .RX_PARITY_ERR(rx_perr), .RX_FRAME_ERR(rx_ferr)
  );

  uart_transceiver_param #(
    .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .CLKS_PER_BIT(4)
  ) dut6 (
    .UART_CLK(clk), .UART_RST_N(rst_n),
    .TX_DATA(tx6_data), .TX_VALID(tx6_valid), .TX_READY(tx6_ready), .TX_SERIAL(tx6_serial),
    .RX_SERIAL(tx6_serial), .RX_DATA(rx6_data), .RX_VALID(rx6_valid),
    .RX_PARITY_ERR(rx6_perr), .RX_FRAME_ERR(rx6_ferr)
  );

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         cyc;
  } rx_ev_t;

  rx_ev_t evq[$];
  rx_ev_t ev6q[$];
  logic   flag_seen = 1'b0;

  always @(negedge clk) begin
    if (rx_valid)  evq.push_back('{d: rx_data, pe: rx_perr, fe: rx_ferr, cyc: cyc});
    if (rx6_valid) ev6q.push_back('{d: {1'b0, rx6_data}, pe: rx6_perr, fe: rx6_ferr, cyc: cyc});
    if (loop_en && (rx_perr || rx_ferr)) flag_seen = 1'b1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference line level k cycles after the start edge of a frame.
  function automatic logic frame_bit(input logic [8:0] data, input int k, input int nb,
                                     input int pen, input int podd, input int cpb);
    int b;
    b = k / cpb;
    if (b == 0) return 1'b0;
    if (b <= nb) return data[b-1];
    if (pen != 0 && b == nb + 1) return 1'(($countones(data) + podd) % 2);
    return 1'b1;
  endfunction

  task automatic check_rx(input bit sel, input string name, input logic [7:0] d,
                          input logic pe, input logic fe, input int lat, input int c0);
    rx_ev_t e;
    int     n;
    n = sel ? ev6q.size() : evq.size();
    check({name, "_count"}, n, 1);
    if (n > 0) begin
      e = sel ? ev6q.pop_front() : evq.pop_front();
      check({name, "_data"}, e.d, d);
      check({name, "_perr"}, e.pe, pe);
      check({name, "_ferr"}, e.fe, fe);
      if (lat >= 0) check({name, "_latency"}, e.cyc - c0, lat);
    end
    if (sel) ev6q.delete(); else evq.delete();
  endtask

  task automatic send_tx(input logic [7:0] d, input string name);
    int bad, first_bad, t;
    bad = 0; first_bad = -1; t = 0;
    while (!tx_ready && t < 400) begin @(negedge clk); t++; end
    check({name, "_ready_wait"}, tx_ready, 1);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      tx_data = 8'($urandom);
      if (tx_ready !== 1'b0 || tx_serial !== frame_bit({1'b0, d}, k, DB, 1, 0, CPB)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      @(negedge clk);
    end
    if (bad != 0) $display("  %s first bad cycle %0d", name, first_bad);
    check({name, "_wave_bad_cycles"}, bad, 0);
    check({name, "_ready_after"}, tx_ready, 1);
    check({name, "_line_idle"}, tx_serial, 1);
  endtask

  task automatic send_tx6(input logic [6:0] d, input string name);
    int bad, t;
    bad = 0; t = 0;
    while (!tx6_ready && t < 100) begin @(negedge clk); t++; end
    check({name, "_ready_wait"}, tx6_ready, 1);
    tx6_data = d; tx6_valid = 1'b1;
    @(negedge clk);
    tx6_valid = 1'b0;
    for (int k = 0; k < FRAME6; k++) begin
      tx6_data = 7'($urandom);
      if (tx6_ready !== 1'b0 || tx6_serial !== frame_bit({2'b0, d}, k, DB6, 0, 0, CPB6)) bad++;
      @(negedge clk);
    end
    check({name, "_wave_bad_cycles"}, bad, 0);
    check({name, "_ready_after"}, tx6_ready, 1);
  endtask

  // Drives one frame on the default instance's RX line from the bench.
  task automatic drive_rx(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                          input int low_extra);
    logic par;
    par = 1'($countones(d) % 2) ^ bad_par;
    rx_drive = 1'b0; repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx_drive = d[i]; repeat (CPB) @(negedge clk);
    end
    rx_drive = par; repeat (CPB) @(negedge clk);
    if (bad_stop) begin
      rx_drive = 1'b0; repeat (CPB + low_extra) @(negedge clk);
    end else begin
      rx_drive = 1'b1; repeat (CPB) @(negedge clk);
    end
    rx_drive = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       bad_par;
    logic       bad_stop;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } rx_vec_t;

  rx_vec_t vt[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int c0, h0, h1, t;
    logic h1_line;
    logic [7:0] rd;
    logic [6:0] rd6;
    logic bp, bs;

    vt[0] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vt[1] = '{8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
    vt[2] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vt[3] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
    vt[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};
    vt[5] = '{8'h6E, 1'b1, 1'b0, 8'h6E, 1'b1, 1'b0};

    tx_data = '0; tx_valid = 1'b0; tx6_data = '0; tx6_valid = 1'b0;
    rx_drive = 1'b1; loop_en = 1'b0; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx_serial", tx_serial, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_perr", rx_perr, 0);
    check("rst_rx_ferr", rx_ferr, 0);
    check("rst_tx6_serial", tx6_serial, 1);
    check("rst_rx6_data", rx6_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback: fixed words, then back-to-back, then random words.
    loop_en = 1'b1;
    send_tx(8'hA5, "t1_a5");
    check_rx(0, "t2_a5", 8'hA5, 0, 0, -1, 0);
    send_tx(8'h3C, "t2_3c");
    check_rx(0, "t2_3c", 8'h3C, 0, 0, -1, 0);

    h0 = -1; h1 = -1; h1_line = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b1;
    for (t = 0; t < 600 && h1 < 0; t++) begin
      if (tx_ready) begin
        if (h0 < 0) h0 = cyc;
        else begin h1 = cyc; h1_line = tx_serial; end
      end
      @(negedge clk);
      if (h0 >= 0 && h1 < 0) tx_data = 8'hFF;
    end
    tx_valid = 1'b0;
    check("t3_handshake_gap", h1 - h0, 177);
    check("t3_idle_line_high", h1_line, 1);
    repeat (FRAME + 10) @(negedge clk);
    check("t3_rx_count", evq.size(), 2);
    if (evq.size() == 2) begin
      check("t3_rx_first", evq[0].d, 8'h00);
      check("t3_rx_second", evq[1].d, 8'hFF);
    end
    evq.delete();

    for (int i = 0; i < 5; i++) begin
      rd = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send_tx(rd, "rand_tx");
      check_rx(0, "rand_loop", rd, 0, 0, -1, 0);
    end
    check("t2_flags_quiet", flag_seen, 0);
    loop_en = 1'b0;
    repeat (10) @(negedge clk);

    // Bench-driven RX frames from the vector table.
    foreach (vt[i]) begin
      c0 = cyc;
      drive_rx(vt[i].d, vt[i].bad_par, vt[i].bad_stop, 0);
      check_rx(0, "rx_vec", vt[i].exp_d, vt[i].exp_pe, vt[i].exp_fe, RX_LAT, c0);
    end

    // Parity error, then a short glitch that must not produce a word.
    drive_rx(8'h01, 1'b1, 1'b0, 0);
    check_rx(0, "t4_par", 8'h01, 1, 0, -1, 0);
    rx_drive = 1'b0; repeat (4) @(negedge clk);
    rx_drive = 1'b1; repeat (40) @(negedge clk);
    check("t4_glitch_no_valid", evq.size(), 0);
    check("t4_perr_held", rx_perr, 1);

    // Framing error with the line held low (break), then recovery.
    c0 = cyc;
    drive_rx(8'h55, 1'b0, 1'b1, 300 - CPB);
    check_rx(0, "t5_break", 8'h55, 0, 1, RX_LAT, c0);
    check("t5_ferr_held", rx_ferr, 1);
    drive_rx(8'hA5, 1'b0, 1'b0, 0);
    check_rx(0, "t5_recover", 8'hA5, 0, 0, -1, 0);

    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom);
      bp = 1'($urandom_range(0, 1));
      bs = 1'($urandom_range(0, 1));
      c0 = cyc;
      drive_rx(rd, bp, bs, int'($urandom_range(0, 40)));
      check_rx(0, "rand_rx", rd, bp, bs, RX_LAT, c0);
    end

    // Second configuration: 7 data bits, no parity, 2 stop bits, 4 clocks/bit.
    send_tx6(7'h55, "t6_55");
    repeat (10) @(negedge clk);
    check_rx(1, "t6_55", 8'h55, 0, 0, -1, 0);
    for (int i = 0; i < 3; i++) begin
      rd6 = 7'($urandom);
      send_tx6(rd6, "rand_tx6");
      repeat (10) @(negedge clk);
      check_rx(1, "rand_rx6", {1'b0, rd6}, 0, 0, -1, 0);
    end

    tx6_data = 7'h2A; tx6_valid = 1'b1;
    @(negedge clk);
    tx6_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("t6_midframe_busy", tx6_ready, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_line_high", tx6_serial, 1);
    check("t6_rst_ready", tx6_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("t6_rst_no_valid", ev6q.size(), 0);
    send_tx6(7'h3A, "t6_after_rst");
    repeat (10) @(negedge clk);
    check_rx(1, "t6_after_rst", 8'h3A, 0, 0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
